// File: rtl/cordic_arbiter_pkg.sv
// Shared definitions for the CORDIC arbiter: FSM state type, core data width
// and the fixed-point constants that clients use to build core operands.
package cordic_pkg;

  localparam int CORDIC_W = 32;

  // CORDIC gain compensation 1/K ~= 0.607253 in Q2.30. Clients load it as x0
  // so that the rotated vector comes out with unit magnitude.
  localparam logic [CORDIC_W-1:0] CORDIC_K = 32'h26DD3B6A;

  // Angle unit for z: signed binary angle, full 32-bit range is one turn,
  // so one LSB is pi / 2^31 rad and 32'h4000_0000 is +90 degrees.
  localparam int                  ANGLE_FRAC_BITS = 31;
  localparam logic [CORDIC_W-1:0] ANGLE_QUARTER   = 32'h4000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin priority encoder. The search starts one position
// after ptr (the last winner) and wraps, so the last winner has lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW-1:0] cand;

  // scan NREQ positions starting at ptr+1; first requester found wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = PW'((int'(ptr) + off) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC core among NREQ requesters.
// One job in flight at a time: operands are captured at grant, the core is
// cleared, loaded and started, and its result (or a timeout error) is
// returned to the owner on a one-cycle response pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | arbitrate; grant pulse and operand capture when any req
//   CLR   | core_rst high for one cycle
//   LOAD  | operands settle at the core, start still low
//   RUN   | core_start high, watchdog counting, wait for core_done
//   RESP  | rsp_valid[owner] pulse, rsp_err qualifies it
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = CORDIC_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  input  logic [NREQ*W-1:0] z_in,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [W-1:0]      rsp_x,
  output logic [W-1:0]      rsp_y,
  output logic [W-1:0]      rsp_z,
  output logic              core_rst,
  output logic              core_start,
  output logic [W-1:0]      core_x0,
  output logic [W-1:0]      core_y0,
  output logic [W-1:0]      core_z0,
  input  logic              core_done,
  input  logic [W-1:0]      core_X,
  input  logic [W-1:0]      core_Y,
  input  logic [W-1:0]      core_Z
);

  localparam int            PW       = $clog2(NREQ);
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            err_q;
  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            any_req;
  logic            accept;
  logic            run_hit;
  logic            run_expire;
  logic [W-1:0]    x_arr [NREQ];
  logic [W-1:0]    y_arr [NREQ];
  logic [W-1:0]    z_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign x_arr[gi] = x_in[gi*W +: W];
    assign y_arr[gi] = y_in[gi*W +: W];
    assign z_arr[gi] = z_in[gi*W +: W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign any_req    = |req;
  assign accept     = (state == ST_IDLE) && any_req;
  // done has priority over the watchdog when both land in the same cycle
  assign run_hit    = (state == ST_RUN) && core_done;
  assign run_expire = (state == ST_RUN) && !core_done && (cnt == CNT_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_CLR;
      ST_CLR:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (core_done || (cnt == CNT_LAST)) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state-decoded outputs; everything but core_rst is forced quiet while rst is low
  always_comb begin
    grant      = '0;
    busy       = 1'b0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    core_rst   = !rst;
    core_start = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          grant = pick_gnt;
          busy  = any_req;
        end
        ST_CLR: begin
          busy     = 1'b1;
          core_rst = 1'b1;
        end
        ST_LOAD: busy = 1'b1;
        ST_RUN: begin
          busy       = 1'b1;
          core_start = 1'b1;
        end
        ST_RESP: begin
          busy           = 1'b1;
          rsp_valid[ptr] = 1'b1;
          rsp_err        = err_q;
        end
        default: ;
      endcase
    end
  end

  // job ownership and operand capture at grant; ptr doubles as the owner index
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= PW'(NREQ - 1);
      core_x0 <= '0;
      core_y0 <= '0;
      core_z0 <= '0;
    end else if (accept) begin
      ptr     <= pick_idx;
      core_x0 <= x_arr[pick_idx];
      core_y0 <= y_arr[pick_idx];
      core_z0 <= z_arr[pick_idx];
    end
  end

  // watchdog: cleared in LOAD so the first RUN cycle sees zero
  always_ff @(posedge clk) begin
    if (!rst)                  cnt <= '0;
    else if (state == ST_LOAD) cnt <= '0;
    else if (state == ST_RUN)  cnt <= cnt + CW'(1);
  end

  // result registers hold until the next job finishes
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_x <= '0;
      rsp_y <= '0;
      rsp_z <= '0;
      err_q <= 1'b0;
    end else if (run_hit) begin
      rsp_x <= core_X;
      rsp_y <= core_Y;
      rsp_z <= core_Z;
      err_q <= 1'b0;
    end else if (run_expire) begin
      rsp_x <= '0;
      rsp_y <= '0;
      rsp_z <= '0;
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter: a transaction-level schedule model checks every
// output every cycle; directed scenarios pin the model with literal values.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in, y_in, z_in;
  logic [NREQ-1:0]   grant, rsp_valid;
  logic              busy, rsp_err, core_rst, core_start, core_done;
  logic [W-1:0]      rsp_x, rsp_y, rsp_z, core_x0, core_y0, core_z0;
  logic [W-1:0]      core_X, core_Y, core_Z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .grant(grant), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .core_rst(core_rst), .core_start(core_start),
    .core_x0(core_x0), .core_y0(core_y0), .core_z0(core_z0),
    .core_done(core_done), .core_X(core_X), .core_Y(core_Y), .core_Z(core_Z)
  );

  function automatic logic [W-1:0] fx(input logic [W-1:0] x); return x ^ 32'h0F0F0F0F; endfunction
  function automatic logic [W-1:0] fy(input logic [W-1:0] y, input logic [W-1:0] z); return y + z; endfunction
  function automatic logic [W-1:0] fz(input logic [W-1:0] z); return z - 32'd7; endfunction

  // core model: done rises after cur_lat cycles of start since the last core_rst
  int sc      = 0;
  int cur_lat = 1000;
  always @(posedge clk) begin
    if (core_rst)        sc <= 0;
    else if (core_start) sc <= sc + 1;
  end
  assign core_done = (sc >= cur_lat);
  assign core_X    = fx(core_x0);
  assign core_Y    = fy(core_y0, core_z0);
  assign core_Z    = fz(core_z0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // behavioural model state
  bit              m_busy  = 0;
  int              m_t     = 0;
  int              m_resp  = 0;
  int              m_owner = 0;
  int              m_ptr   = NREQ - 1;
  bit              m_err   = 0;
  bit              data_ok = 0;
  logic [W-1:0]    m_rx = '0, m_ry = '0, m_rz = '0;
  logic [W-1:0]    m_cx = '0, m_cy = '0, m_cz = '0;
  logic [W-1:0]    j_x, j_y, j_z;
  logic [NREQ-1:0] e_grant = '0;
  int              force_lat = 0;

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg, ev;
    logic ebusy, erst, estart, eerr;
    bit newjob, endjob;
    int w, lat, i;
    eg = '0; ev = '0; ebusy = 0; erst = 0; estart = 0; eerr = 0;
    newjob = 0; endjob = 0;
    if (!rst) begin
      erst = 1;
    end else if (!m_busy) begin
      if (|req) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (w < 0 && req[i]) w = i;
        end
        eg[w] = 1'b1; ebusy = 1; newjob = 1;
        lat = (force_lat > 0) ? force_lat : int'($urandom_range(70, 1));
        m_t = cyc; m_owner = w; m_ptr = w;
        j_x = x_in[w*W +: W]; j_y = y_in[w*W +: W]; j_z = z_in[w*W +: W];
        if (lat <= TIMEOUT - 1) begin m_resp = cyc + 4 + lat; m_err = 0; end
        else begin m_resp = cyc + 3 + TIMEOUT; m_err = 1; end
        cur_lat = lat;
      end
    end else begin
      ebusy  = 1;
      erst   = (cyc - m_t == 1);
      estart = (cyc - m_t >= 3) && (cyc < m_resp);
      if (cyc == m_resp) begin
        ev[m_owner] = 1'b1; eerr = m_err; endjob = 1;
        m_rx = m_err ? '0 : fx(j_x);
        m_ry = m_err ? '0 : fy(j_y, j_z);
        m_rz = m_err ? '0 : fz(j_z);
      end
    end
    e_grant = eg;
    chk("grant", W'(grant), W'(eg));
    chk("busy", W'(busy), W'(ebusy));
    chk("rsp_valid", W'(rsp_valid), W'(ev));
    chk("core_rst", W'(core_rst), W'(erst));
    chk("core_start", W'(core_start), W'(estart));
    if (ev != '0) chk("rsp_err", W'(rsp_err), W'(eerr));
    if (rst && data_ok) begin
      chk("rsp_x", rsp_x, m_rx); chk("rsp_y", rsp_y, m_ry); chk("rsp_z", rsp_z, m_rz);
      chk("core_x0", core_x0, m_cx); chk("core_y0", core_y0, m_cy); chk("core_z0", core_z0, m_cz);
    end
    if (newjob) begin m_cx = j_x; m_cy = j_y; m_cz = j_z; m_busy = 1; end
    if (endjob) m_busy = 0;
    if (!rst) begin
      m_busy = 0; m_ptr = NREQ - 1; data_ok = 1;
      m_rx = '0; m_ry = '0; m_rz = '0; m_cx = '0; m_cy = '0; m_cz = '0;
    end
  end

  // kind 0: grant[idx], 1: rsp_valid[idx], 2: any grant
  task automatic wait_sig(input string name, input int kind, input int idx, input int maxc, output int at);
    bit hit;
    at = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      hit = (kind == 0) ? grant[idx] : (kind == 1) ? rsp_valid[idx] : (|grant);
      if (hit) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL %s actual=no_event required=event_within_%0d", name, maxc);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    x_in[i*W +: W] = x; y_in[i*W +: W] = y; z_in[i*W +: W] = z;
  endtask

  task automatic rand_phase(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(399, 0) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (e_grant[i]) begin
          req[i] = ($urandom_range(3, 0) == 0);
          set_ops(i, $urandom(), $urandom(), $urandom());
        end else if (!req[i]) begin
          if ($urandom_range(5, 0) == 0) begin
            req[i] = 1'b1;
            set_ops(i, $urandom(), $urandom(), $urandom());
          end
        end else if ($urandom_range(31, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, rc, idx;
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 1};
    rst = 1'b0; req = 4'b1111; x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_core_rst", W'(core_rst), 32'd1);
    chk("reset_grant", W'(grant), 32'd0);
    chk("reset_busy", W'(busy), 32'd0);
    @(posedge clk); #1; rst = 1'b1; req = '0;
    @(negedge clk);
    chk("reset_rsp_x", rsp_x, 32'd0);
    chk("reset_core_x0", core_x0, 32'd0);

    // single job
    @(posedge clk); #1; force_lat = 16; req = 4'b0001; set_ops(0, CORDIC_K, 32'd0, 32'd30);
    wait_sig("single_grant", 0, 0, 5, t0);
    @(posedge clk); #1; req[0] = 1'b0; z_in[0 +: W] = 32'd999;
    @(negedge clk); chk("single_core_rst_t1", W'(core_rst), 32'd1);
    @(negedge clk); chk("opchg_core_z0", core_z0, 32'd30); chk("single_start_t2", W'(core_start), 32'd0);
    @(negedge clk); chk("single_start_t3", W'(core_start), 32'd1);
    wait_sig("single_rsp", 1, 0, 40, t1);
    chk("single_latency", W'(t1 - t0), 32'd20);
    chk("single_err", W'(rsp_err), 32'd0);
    chk("single_rsp_x", rsp_x, 32'h29D23465);
    chk("single_rsp_y", rsp_y, 32'd30);
    chk("single_rsp_z", rsp_z, 32'd23);

    // timeout
    @(posedge clk); #1; force_lat = 100; req = 4'b0010; set_ops(1, 32'hDEADBEEF, 32'd4, 32'd9);
    wait_sig("tmo_grant", 0, 1, 5, t0);
    @(posedge clk); #1; req = '0;
    wait_sig("tmo_rsp", 1, 1, 80, t1);
    chk("tmo_latency", W'(t1 - t0), 32'd67);
    chk("tmo_err", W'(rsp_err), 32'd1);
    chk("tmo_rsp_x", rsp_x, 32'd0);
    chk("tmo_rsp_y", rsp_y, 32'd0);
    chk("tmo_rsp_z", rsp_z, 32'd0);
    @(negedge clk); chk("tmo_idle_busy", W'(busy), 32'd0);

    // done and timeout in the same cycle
    @(posedge clk); #1; force_lat = 63; req = 4'b0100; set_ops(2, 32'h12345678, 32'd100, 32'd5);
    wait_sig("coll_grant", 0, 2, 5, t0);
    @(posedge clk); #1; req = '0;
    wait_sig("coll_rsp", 1, 2, 80, t1);
    chk("coll_latency", W'(t1 - t0), 32'd67);
    chk("coll_err", W'(rsp_err), 32'd0);
    chk("coll_rsp_x", rsp_x, 32'h1D3B5977);
    chk("coll_rsp_y", rsp_y, 32'd105);
    chk("coll_rsp_z", rsp_z, 32'hFFFFFFFE);

    // reset in the middle of RUN
    @(posedge clk); #1; force_lat = 40; req = 4'b0010; set_ops(1, 32'd1, 32'd2, 32'd3);
    wait_sig("mid_grant", 0, 1, 5, t0);
    @(posedge clk); #1; req = 4'b0100; set_ops(2, 32'd11, 32'd22, 32'd33);
    repeat (8) @(posedge clk);
    #1; rst = 1'b0; force_lat = 3;
    @(negedge clk);
    chk("mid_core_start", W'(core_start), 32'd0);
    chk("mid_core_rst", W'(core_rst), 32'd1);
    chk("mid_rsp_valid", W'(rsp_valid), 32'd0);
    @(posedge clk); #1; rst = 1'b1; rc = cyc;
    wait_sig("mid_regrant", 0, 2, 5, t2);
    chk("mid_regrant_cycle", W'(t2), W'(rc));
    @(posedge clk); #1; req = '0;
    wait_sig("mid_rsp", 1, 2, 20, t1);

    // all four requesters, req[1] held after its first grant
    @(posedge clk); #1; rst = 1'b0; force_lat = 2; req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom(), $urandom(), $urandom());
    @(posedge clk); #1; rst = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_sig("rr_grant", 2, 0, 30, t0);
      idx = -1;
      for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
      order[g] = idx;
      @(posedge clk); #1;
      if (idx >= 0 && !(idx == 1 && g == 1)) req[idx] = 1'b0;
    end
    for (int g = 0; g < 5; g++) chk($sformatf("rr_order_%0d", g), W'(order[g]), W'(exp_order[g]));
    req = '0;

    // randomized traffic
    force_lat = 0;
    rand_phase(3000);
    @(posedge clk); #1; req = '0; rst = 1'b1;
    for (int n = 0; n < 200 && m_busy; n++) @(negedge clk);
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL drain actual=busy required=idle");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
